// File: rtl/pc_sequencer_if.sv
// Fetch handshake, redirect controls and PC status between the sequencer and its neighbours.
// master = sequencer side; slave = instruction memory plus decode/execute datapath side.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic [31:0] retired;

    modport master (
        output imem_req, imem_addr, instr_valid, pc, pc_plus4, misaligned, retired,
        input  imem_ack, stall, branch_taken, branch_target, jump, jump_target, halt, resume
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, pc, pc_plus4, misaligned, retired,
        output imem_ack, stall, branch_taken, branch_target, jump, jump_target, halt, resume
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC owner: FETCH/EXEC/HALT sequencing with jump > branch > pc+4 selection and a sticky misalignment trap.
// Two cycles per instruction minimum; imem_ack low stretches FETCH, stall high stretches EXEC.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    pc_sequencer_if.master    bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        if (bus.jump) begin
            next_pc = bus.jump_target;
        end else if (bus.branch_taken) begin
            next_pc = bus.branch_target;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        retired_d    = retired_q;
        case (state_q)
            FETCH: begin
                if (bus.imem_ack) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!bus.stall) begin
                    // A misaligned target traps before anything commits, even with halt set.
                    if (next_pc[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                        state_d      = HALT;
                    end else begin
                        pc_d      = next_pc;
                        retired_d = retired_q + 32'd1;
                        state_d   = bus.halt ? HALT : FETCH;
                    end
                end
            end
            HALT: begin
                if (bus.resume && !misaligned_q) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
            retired_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            retired_q    <= retired_d;
        end
    end

    assign bus.imem_req    = (state_q == FETCH);
    assign bus.instr_valid = (state_q == EXEC);
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.misaligned  = misaligned_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs change and outputs are checked on the falling edge.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.imem_ack      = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.jump          = 1'b0;
        bus.jump_target   = 32'h0;
        bus.halt          = 1'b0;
        bus.resume        = 1'b0;
    endtask

    // From a FETCH cycle with no wait: accept, then retire with the given redirect.
    task automatic run_instr(input logic jmp, input logic [31:0] jt,
                             input logic br, input logic [31:0] bt);
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack      = 1'b0;
        bus.jump          = jmp;
        bus.jump_target   = jt;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b want 1", bus.imem_req); end
        checks++;
        if (bus.imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, RST_PC); end
        checks++;
        if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
        checks++;
        if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", bus.misaligned); end
        checks++;
        if (bus.retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
        checks++;
        if (bus.pc_plus4 !== 32'h0040_0004) begin errors++; $display("FAIL reset_pc_plus4: got %h want 00400004", bus.pc_plus4); end
        checks++;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_addr = RST_PC + 32'(4 * (i / 2));
            if (bus.imem_req !== ((i % 2) == 0)) begin
                errors++; $display("FAIL seq_req[%0d]: got %b want %b", i, bus.imem_req, ((i % 2) == 0));
            end
            checks++;
            if (bus.instr_valid !== ((i % 2) == 1)) begin
                errors++; $display("FAIL seq_valid[%0d]: got %b want %b", i, bus.instr_valid, ((i % 2) == 1));
            end
            checks++;
            if (bus.imem_addr !== exp_addr) begin
                errors++; $display("FAIL seq_addr[%0d]: got %h want %h", i, bus.imem_addr, exp_addr);
            end
            checks++;
            step();
        end
        bus.imem_ack = 1'b0;
        if (bus.retired !== 32'd3) begin errors++; $display("FAIL seq_retired: got %0d want 3", bus.retired); end
        checks++;
        if (bus.imem_addr !== 32'h0040_000C) begin errors++; $display("FAIL seq_next_addr: got %h want 0040000c", bus.imem_addr); end
        checks++;
    endtask

    // ack low 3 cycles, then stall 2 cycles; redirects presented while waiting must be ignored.
    task automatic test_wait_stall();
        for (int k = 0; k < 4; k++) begin
            bus.imem_ack    = (k == 3);
            bus.jump        = (k < 3);
            bus.jump_target = 32'h0000_0200;
            bus.halt        = (k < 3);
            if (bus.imem_req !== 1'b1 || bus.pc !== 32'h0040_000C) begin
                errors++; $display("FAIL wait_fetch[%0d]: req=%b pc=%h want req=1 pc=0040000c", k, bus.imem_req, bus.pc);
            end
            checks++;
            step();
        end
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            bus.stall        = (k < 2);
            bus.jump         = (k < 2);
            bus.jump_target  = 32'h0000_0200;
            bus.halt         = (k < 2);
            if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h0040_000C || bus.retired !== 32'd3) begin
                errors++; $display("FAIL stall_exec[%0d]: valid=%b pc=%h retired=%0d want 1/0040000c/3",
                                   k, bus.instr_valid, bus.pc, bus.retired);
            end
            checks++;
            step();
        end
        clear_inputs();
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0010) begin
            errors++; $display("FAIL stall_after: req=%b addr=%h want 1/00400010", bus.imem_req, bus.imem_addr);
        end
        checks++;
        if (bus.retired !== 32'd4) begin errors++; $display("FAIL stall_retired: got %0d want 4", bus.retired); end
        checks++;
    endtask

    task automatic test_jump_priority();
        run_instr(1'b1, 32'h0000_0100, 1'b0, 32'h0);
        if (bus.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL jump_addr: got %h want 00000100", bus.imem_addr); end
        checks++;
        run_instr(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300);
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0200) begin
            errors++; $display("FAIL jump_wins: req=%b addr=%h want 1/00000200", bus.imem_req, bus.imem_addr);
        end
        checks++;
        run_instr(1'b0, 32'h0000_0500, 1'b1, 32'h0000_0300);
        if (bus.imem_addr !== 32'h0000_0300) begin errors++; $display("FAIL branch_addr: got %h want 00000300", bus.imem_addr); end
        checks++;
        if (bus.retired !== 32'd7) begin errors++; $display("FAIL redirect_retired: got %0d want 7", bus.retired); end
        checks++;
    endtask

    task automatic test_wrap();
        run_instr(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        if (bus.pc_plus4 !== 32'h0000_0000) begin errors++; $display("FAIL wrap_plus4: got %h want 00000000", bus.pc_plus4); end
        checks++;
        run_instr(1'b0, 32'h0, 1'b0, 32'h0);
        if (bus.imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", bus.imem_addr); end
        checks++;
        if (bus.pc_plus4 !== 32'h0000_0004) begin errors++; $display("FAIL wrap_plus4_after: got %h want 00000004", bus.pc_plus4); end
        checks++;
    endtask

    task automatic test_halt_resume();
        bus.imem_ack = 1'b1;
        step();
        clear_inputs();
        bus.halt          = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0080;
        step();
        clear_inputs();
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== 32'h0000_0080) begin
            errors++; $display("FAIL halt_enter: req=%b valid=%b pc=%h want 0/0/00000080", bus.imem_req, bus.instr_valid, bus.pc);
        end
        checks++;
        if (bus.retired !== 32'd10) begin errors++; $display("FAIL halt_retired: got %0d want 10", bus.retired); end
        checks++;
        bus.imem_ack = 1'b1;
        step();
        if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL halt_hold: req=%b want 0", bus.imem_req); end
        checks++;
        bus.imem_ack = 1'b0;
        bus.resume   = 1'b1;
        step();
        bus.resume = 1'b0;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0080) begin
            errors++; $display("FAIL resume_fetch: req=%b addr=%h want 1/00000080", bus.imem_req, bus.imem_addr);
        end
        checks++;
    endtask

    // Halt and a misaligned branch together: the trap wins and pc stays put.
    task automatic test_misaligned();
        bus.imem_ack = 1'b1;
        step();
        clear_inputs();
        bus.halt          = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0102;
        step();
        clear_inputs();
        if (bus.misaligned !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", bus.misaligned); end
        checks++;
        if (bus.pc !== 32'h0000_0080 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL mis_state: pc=%h req=%b valid=%b want 00000080/0/0", bus.pc, bus.imem_req, bus.instr_valid);
        end
        checks++;
        if (bus.retired !== 32'd10) begin errors++; $display("FAIL mis_retired: got %0d want 10", bus.retired); end
        checks++;
        bus.resume = 1'b1;
        step();
        step();
        bus.resume = 1'b0;
        if (bus.imem_req !== 1'b0 || bus.misaligned !== 1'b1 || bus.pc !== 32'h0000_0080) begin
            errors++; $display("FAIL mis_resume_ignored: req=%b mis=%b pc=%h want 0/1/00000080", bus.imem_req, bus.misaligned, bus.pc);
        end
        checks++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        if (bus.misaligned !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC || bus.retired !== 32'd0) begin
            errors++; $display("FAIL mis_reset: mis=%b req=%b addr=%h retired=%0d want 0/1/%h/0",
                               bus.misaligned, bus.imem_req, bus.imem_addr, bus.retired, RST_PC);
        end
        checks++;
    endtask

    // Reset during a stalled EXEC with a jump pending: nothing retires, fetch restarts at RESET_PC.
    task automatic test_reset_mid_stall();
        run_instr(1'b1, 32'h0000_0040, 1'b0, 32'h0);
        bus.imem_ack = 1'b1;
        step();
        clear_inputs();
        bus.stall       = 1'b1;
        bus.jump        = 1'b1;
        bus.jump_target = 32'h0000_0800;
        step();
        if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h0000_0040 || bus.retired !== 32'd1) begin
            errors++; $display("FAIL mid_pre: valid=%b pc=%h retired=%0d want 1/00000040/1", bus.instr_valid, bus.pc, bus.retired);
        end
        checks++;
        bus.stall = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        if (bus.imem_req !== 1'b1 || bus.pc !== RST_PC || bus.retired !== 32'd0 || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset: req=%b pc=%h retired=%0d valid=%b want 1/%h/0/0",
                               bus.imem_req, bus.pc, bus.retired, bus.instr_valid, RST_PC);
        end
        checks++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_wait_stall();
        test_jump_priority();
        test_wrap();
        test_halt_resume();
        test_misaligned();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
